// File: rtl/div_pkg.sv
// div_pkg
// Shared definitions for the hi/lo divider and the decoders that issue it.
//   div_state_e : divider FSM states (IDLE, RUN, FIXUP, DONE)
//   DIV_WIDTH   : default operand/result width
//   FUNCT_DIV / FUNCT_DIVU : R-type funct codes for div / divu
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_e;

  localparam int DIV_WIDTH = 32;

  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;

endpackage

// File: rtl/div_step.sv
// div_step
// One combinational restoring-division step.
//   rem_i, quo_i   : partial remainder and quotient/dividend shift register
//   divisor_mag_i  : divisor magnitude (unsigned)
//   rem_o, quo_o   : values after shifting left by one and conditionally subtracting
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_mag_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  // The shifted remainder keeps its carry-out bit: with a divisor above
  // 2^(WIDTH-1) the partial remainder can briefly need WIDTH+1 bits.
  logic [WIDTH:0]   rem_shifted;
  // One extra bit beyond that so the borrow is a clean sign bit.
  logic [WIDTH+1:0] trial;
  // A successful subtraction always leaves a value below the divisor, so
  // bit WIDTH of the difference is structurally zero.
  logic             trial_msb_unused;

  assign rem_shifted      = {rem_i, quo_i[WIDTH-1]};
  assign trial            = {1'b0, rem_shifted} - {2'b00, divisor_mag_i};
  assign trial_msb_unused = trial[WIDTH];

  always_comb begin
    if (!trial[WIDTH+1]) begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = rem_shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_divider.sv
// hilo_divider
// Multi-cycle restoring divider for MIPS div/divu, producing lo (quotient)
// and hi (remainder). One quotient bit per cycle, then a sign fix-up cycle.
//   clk, reset           : clock, synchronous active-high reset
//   start, is_signed     : request and signedness, sampled when not busy
//   dividend, divisor    : operands, sampled with start
//   busy                 : operation in progress (RUN or FIXUP)
//   done                 : one-cycle pulse when results become valid
//   quotient, remainder  : results, held until the next done
//   div_by_zero          : last completed operation had a zero divisor
module hilo_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int             CW         = $clog2(WIDTH);
  localparam logic [CW-1:0]  COUNT_LOAD = CW'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_rem, step_quo;
  logic             dividend_neg, divisor_neg;
  logic [WIDTH-1:0] dividend_mag, divisor_mag;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i         (rem_q),
    .quo_i         (quo_q),
    .divisor_mag_i (dmag_q),
    .rem_o         (step_rem),
    .quo_o         (step_quo)
  );

  // Negating the most negative value yields itself, which read as unsigned
  // is exactly its magnitude; this makes MIN / -1 fall out naturally.
  assign dividend_neg = is_signed & dividend[WIDTH-1];
  assign divisor_neg  = is_signed & divisor[WIDTH-1];
  assign dividend_mag = dividend_neg ? -dividend : dividend;
  assign divisor_mag  = divisor_neg  ? -divisor  : divisor;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dmag_d      = dmag_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      // DONE accepts a new request exactly like IDLE so results can be
      // consumed and the next divide issued in the same cycle.
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          if (divisor == '0) begin
            // No iterations needed: publish the fixed results directly.
            state_d     = DONE;
            done_d      = 1'b1;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
            count_d = COUNT_LOAD;
            rem_d   = '0;
            quo_d   = dividend_mag;
            dmag_d  = divisor_mag;
            q_neg_d = dividend_neg ^ divisor_neg;
            r_neg_d = dividend_neg;
          end
        end
      end

      RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (count_q == '0) begin
          state_d = FIXUP;
        end else begin
          count_d = count_q - CW'(1);
        end
      end

      FIXUP: begin
        state_d     = DONE;
        busy_d      = 1'b0;
        done_d      = 1'b1;
        quotient_d  = q_neg_q ? -quo_q : quo_q;
        remainder_d = r_neg_q ? -rem_q : rem_q;
        dbz_d       = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dmag_q      <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dmag_q      <= dmag_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_hilo_divider.sv
// tb_hilo_divider
// Directed tests for hilo_divider: reset, timing, signed/unsigned arithmetic,
// divide by zero, abort by reset, ignored start and back-to-back operation.
module tb_hilo_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;

  // observations from the most recent run_op
  int           o_busy_first;
  int           o_busy_last;
  int           o_busy_cnt;
  int           o_done_c;
  logic [W-1:0] o_q;
  logic [W-1:0] o_r;
  logic         o_dbz;

  hilo_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Called 1 time unit after an edge; start is sampled at the next edge (k),
  // and the task returns 1 time unit into cycle k+1.
  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    start     = 1'b1;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = 32'hDEAD_BEEF;
    divisor   = 32'h1234_5678;
  endtask

  // Issue one divide and watch it up to done (bounded). Returns inside the
  // done cycle. inject_at > 0 drives a spurious 1/1 start in that cycle.
  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inject_at);
    issue(s, a, b);
    o_busy_first = 0;
    o_busy_last  = 0;
    o_busy_cnt   = 0;
    o_done_c     = 0;
    o_q          = '0;
    o_r          = '0;
    o_dbz        = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (busy) begin
        if (o_busy_first == 0) o_busy_first = c;
        o_busy_last = c;
        o_busy_cnt++;
      end
      if (done) begin
        o_done_c = c;
        o_q      = quotient;
        o_r      = remainder;
        o_dbz    = div_by_zero;
        break;
      end
      if (c == inject_at) begin
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd1;
        divisor   = 32'd1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    $display("op s=%0d %h / %h -> q=%h r=%h dbz=%0d done@%0d busy=%0d..%0d",
             s, a, b, o_q, o_r, o_dbz, o_done_c, o_busy_first, o_busy_last);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    $display("reset: busy=%0d done=%0d q=%h r=%h dbz=%0d", busy, done, quotient, remainder, div_by_zero);
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%0d want=0", busy); end
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL reset_done got=%0d want=0", done); end
    total++; if (quotient !== '0)      begin bad++; $display("FAIL reset_quotient got=%h want=0", quotient); end
    total++; if (remainder !== '0)     begin bad++; $display("FAIL reset_remainder got=%h want=0", remainder); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%0d want=0", div_by_zero); end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_timing();
    run_op(1'b0, 32'd100, 32'd7, 0);
    total++; if (o_busy_first != 1)  begin bad++; $display("FAIL timing_busy_first got=%0d want=1", o_busy_first); end
    total++; if (o_busy_last != 33)  begin bad++; $display("FAIL timing_busy_last got=%0d want=33", o_busy_last); end
    total++; if (o_busy_cnt != 33)   begin bad++; $display("FAIL timing_busy_cnt got=%0d want=33", o_busy_cnt); end
    total++; if (o_done_c != 34)     begin bad++; $display("FAIL timing_done_cycle got=%0d want=34", o_done_c); end
    total++; if (o_q !== 32'd14)     begin bad++; $display("FAIL timing_quotient got=%h want=%h", o_q, 32'd14); end
    total++; if (o_r !== 32'd2)      begin bad++; $display("FAIL timing_remainder got=%h want=%h", o_r, 32'd2); end
    total++; if (o_dbz !== 1'b0)     begin bad++; $display("FAIL timing_dbz got=%0d want=0", o_dbz); end
    @(posedge clk);
    #1;
    total++; if (done !== 1'b0)          begin bad++; $display("FAIL timing_done_pulse got=%0d want=0", done); end
    total++; if (quotient !== 32'd14)    begin bad++; $display("FAIL timing_hold_q got=%h want=%h", quotient, 32'd14); end
    total++; if (remainder !== 32'd2)    begin bad++; $display("FAIL timing_hold_r got=%h want=%h", remainder, 32'd2); end
  endtask

  task automatic test_arith();
    logic         vs [7];
    logic [W-1:0] va [7];
    logic [W-1:0] vb [7];
    logic [W-1:0] eq [7];
    logic [W-1:0] er [7];
    vs[0] = 1'b1; va[0] = 32'hFFFF_FFF9; vb[0] = 32'd2;          eq[0] = 32'hFFFF_FFFD; er[0] = 32'hFFFF_FFFF;
    vs[1] = 1'b1; va[1] = 32'h8000_0000; vb[1] = 32'hFFFF_FFFF;  eq[1] = 32'h8000_0000; er[1] = 32'h0;
    vs[2] = 1'b0; va[2] = 32'hFFFF_FFFF; vb[2] = 32'h10;         eq[2] = 32'h0FFF_FFFF; er[2] = 32'hF;
    vs[3] = 1'b1; va[3] = 32'd7;         vb[3] = 32'hFFFF_FFFE;  eq[3] = 32'hFFFF_FFFD; er[3] = 32'd1;
    vs[4] = 1'b1; va[4] = 32'hFFFF_FFF9; vb[4] = 32'hFFFF_FFFE;  eq[4] = 32'd3;         er[4] = 32'hFFFF_FFFF;
    vs[5] = 1'b0; va[5] = 32'hFFFF_FFFF; vb[5] = 32'hFFFF_FFFE;  eq[5] = 32'd1;         er[5] = 32'd1;
    vs[6] = 1'b0; va[6] = 32'hFFFF_FFF9; vb[6] = 32'd2;          eq[6] = 32'h7FFF_FFFC; er[6] = 32'd1;
    for (int i = 0; i < 7; i++) begin
      run_op(vs[i], va[i], vb[i], 0);
      total++; if (o_done_c != 34)  begin bad++; $display("FAIL arith%0d_done_cycle got=%0d want=34", i, o_done_c); end
      total++; if (o_q !== eq[i])   begin bad++; $display("FAIL arith%0d_quotient got=%h want=%h", i, o_q, eq[i]); end
      total++; if (o_r !== er[i])   begin bad++; $display("FAIL arith%0d_remainder got=%h want=%h", i, o_r, er[i]); end
      total++; if (o_dbz !== 1'b0)  begin bad++; $display("FAIL arith%0d_dbz got=%0d want=0", i, o_dbz); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_div_zero();
    logic         vs [3];
    logic [W-1:0] va [3];
    vs[0] = 1'b0; va[0] = 32'd5;
    vs[1] = 1'b1; va[1] = 32'd5;
    vs[2] = 1'b1; va[2] = 32'hFFFF_FFFB;
    for (int i = 0; i < 3; i++) begin
      run_op(vs[i], va[i], 32'd0, 0);
      total++; if (o_done_c != 1)          begin bad++; $display("FAIL dbz%0d_done_cycle got=%0d want=1", i, o_done_c); end
      total++; if (o_busy_cnt != 0)        begin bad++; $display("FAIL dbz%0d_busy_cnt got=%0d want=0", i, o_busy_cnt); end
      total++; if (o_q !== 32'hFFFF_FFFF)  begin bad++; $display("FAIL dbz%0d_quotient got=%h want=ffffffff", i, o_q); end
      total++; if (o_r !== va[i])          begin bad++; $display("FAIL dbz%0d_remainder got=%h want=%h", i, o_r, va[i]); end
      total++; if (o_dbz !== 1'b1)         begin bad++; $display("FAIL dbz%0d_flag got=%0d want=1", i, o_dbz); end
      @(posedge clk);
      #1;
      total++; if (div_by_zero !== 1'b1)   begin bad++; $display("FAIL dbz%0d_hold got=%0d want=1", i, div_by_zero); end
    end
    run_op(1'b0, 32'd9, 32'd3, 0);
    total++; if (o_done_c != 34)     begin bad++; $display("FAIL after_dbz_done_cycle got=%0d want=34", o_done_c); end
    total++; if (o_q !== 32'd3)      begin bad++; $display("FAIL after_dbz_quotient got=%h want=%h", o_q, 32'd3); end
    total++; if (o_r !== 32'd0)      begin bad++; $display("FAIL after_dbz_remainder got=%h want=0", o_r); end
    total++; if (o_dbz !== 1'b0)     begin bad++; $display("FAIL after_dbz_flag got=%0d want=0", o_dbz); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int done_seen;
    issue(1'b0, 32'd50, 32'd5);
    repeat (9) @(posedge clk);
    #1;
    // now in RUN cycle k+10
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    $display("reset_mid: busy=%0d done=%0d q=%h r=%h dbz=%0d", busy, done, quotient, remainder, div_by_zero);
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rmid_busy got=%0d want=0", busy); end
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL rmid_done got=%0d want=0", done); end
    total++; if (quotient !== '0)      begin bad++; $display("FAIL rmid_quotient got=%h want=0", quotient); end
    total++; if (remainder !== '0)     begin bad++; $display("FAIL rmid_remainder got=%h want=0", remainder); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL rmid_dbz got=%0d want=0", div_by_zero); end
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done || busy) done_seen++;
      @(posedge clk);
      #1;
    end
    total++; if (done_seen != 0)       begin bad++; $display("FAIL rmid_activity got=%0d want=0", done_seen); end
  endtask

  task automatic test_ignore_start();
    run_op(1'b0, 32'd1000, 32'd10, 5);
    total++; if (o_done_c != 34)     begin bad++; $display("FAIL ignore_done_cycle got=%0d want=34", o_done_c); end
    total++; if (o_q !== 32'd100)    begin bad++; $display("FAIL ignore_quotient got=%h want=%h", o_q, 32'd100); end
    total++; if (o_r !== 32'd0)      begin bad++; $display("FAIL ignore_remainder got=%h want=0", o_r); end
    @(posedge clk);
    #1;
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL ignore_no_requeue got=%0d want=0", busy); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    run_op(1'b0, 32'd100, 32'd7, 0);
    total++; if (o_q !== 32'd14)          begin bad++; $display("FAIL b2b_first_quotient got=%h want=%h", o_q, 32'd14); end
    // issue during the done cycle
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    total++; if (o_busy_first != 1)       begin bad++; $display("FAIL b2b_busy_first got=%0d want=1", o_busy_first); end
    total++; if (o_done_c != 34)          begin bad++; $display("FAIL b2b_done_cycle got=%0d want=34", o_done_c); end
    total++; if (o_q !== 32'hFFFF_FFFD)   begin bad++; $display("FAIL b2b_quotient got=%h want=fffffffd", o_q); end
    total++; if (o_r !== 32'hFFFF_FFFF)   begin bad++; $display("FAIL b2b_remainder got=%h want=ffffffff", o_r); end
    // two divide-by-zero requests back to back: done high in consecutive cycles
    run_op(1'b0, 32'd5, 32'd0, 0);
    run_op(1'b0, 32'd6, 32'd0, 0);
    total++; if (o_done_c != 1)           begin bad++; $display("FAIL b2b_dbz_done_cycle got=%0d want=1", o_done_c); end
    total++; if (o_r !== 32'd6)           begin bad++; $display("FAIL b2b_dbz_remainder got=%h want=%h", o_r, 32'd6); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_timing();
    test_arith();
    test_div_zero();
    test_reset_mid();
    test_ignore_start();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
